// File: rtl/mux_dreg_bank.sv
// Multi-channel register bank with synchronous clear and a snapshot sequencer.
// The sequencer streams a frozen copy of every channel over a valid/ready port.
module mux_dreg_bank #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH*NUM_CH-1:0]    d,
  input  logic [NUM_CH-1:0]          load_en,
  input  logic                       clear,
  output logic [WIDTH*NUM_CH-1:0]    q,
  input  logic                       snap_req,
  output logic                       snap_busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic                       out_last
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [NUM_CH-1:0][WIDTH-1:0] r_q;
  logic [NUM_CH-1:0][WIDTH-1:0] w_q_nxt;
  logic [NUM_CH-1:0][WIDTH-1:0] r_shadow;
  state_t                       r_state;
  logic                         r_busy;
  logic                         r_valid;
  logic [WIDTH-1:0]             r_data;
  logic [CH_W-1:0]              r_ch;
  logic                         r_last;
  logic [CH_W-1:0]              w_ch_nxt;

  // Per-channel 2:1 hold mux; clear overrides any load.
  always_comb begin
    w_q_nxt = r_q;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (clear)
        w_q_nxt[k] = '0;
      else if (load_en[k])
        w_q_nxt[k] = d[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= '0;
    else
      r_q <= w_q_nxt;
  end

  assign w_ch_nxt = r_ch + CH_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_ch     <= '0;
      r_last   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Snapshot takes pre-edge q, so same-edge loads/clear are excluded.
          if (snap_req) begin
            r_shadow <= r_q;
            r_state  <= SEND;
            r_busy   <= 1'b1;
            r_valid  <= 1'b1;
            r_data   <= r_q[0];
            r_ch     <= '0;
            r_last   <= 1'b0;
          end
        end
        SEND: begin
          if (r_valid && out_ready) begin
            if (r_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_ch    <= '0;
              r_last  <= 1'b0;
            end else begin
              r_ch   <= w_ch_nxt;
              r_data <= r_shadow[w_ch_nxt];
              r_last <= (w_ch_nxt == CH_W'(NUM_CH - 1));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign q         = r_q;
  assign snap_busy = r_busy;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_last  = r_last;

endmodule

// File: doc/mux_dreg_bank.md
Name: mux_dreg_bank

Overview:
Parametrised multi-channel storage bank. Each of NUM_CH channels is a WIDTH-bit register built from a 2:1 mux-feedback hold loop and clocked by one edge. Adds a synchronous clear and a snapshot/readout sequencer, which streams a frozen copy of all channels over a valid/ready interface. Sits between control logic that writes configuration or sample words and a narrow consumer that reads them back one channel at a time.

Parameters:
- WIDTH, 8, bits per channel; minimum 1.
- NUM_CH, 4, number of channels; minimum 2.
- CH_W, $clog2(NUM_CH), channel-index width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- d  input  WIDTH*NUM_CH  write data; channel k occupies bits [k*WIDTH +: WIDTH].
- load_en  input  NUM_CH  per-channel load enable; bit k loads channel k.
- clear  input  1  synchronous clear of all channel registers.
- q  output  WIDTH*NUM_CH  live channel contents, same packing as d.
- snap_req  input  1  single-cycle request to snapshot and stream the bank.
- snap_busy  output  1  high while a snapshot is being streamed.
- out_valid  output  1  out_data/out_ch/out_last are valid.
- out_ready  input  1  consumer accepts the current word.
- out_data  output  WIDTH  snapshot word of channel out_ch.
- out_ch  output  CH_W  channel index of out_data.
- out_last  output  1  high with the word for channel NUM_CH-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - q = 0, shadow = 0, state = IDLE.
  - snap_busy = 0, out_valid = 0, out_data = 0, out_ch = 0, out_last = 0.
  - Reset takes effect immediately at any point, including mid-stream. Any in-flight transfer is dropped.
- Storage, per channel k, on each rising edge:
  - clear = 1: q_k <= 0. Clear has priority over load_en.
  - else load_en[k] = 1: q_k <= d_k.
  - else q_k holds (mux feedback).
  - q is registered, so a load is visible one cycle after the edge that samples it.
- Sequencer FSM, two states: IDLE and SEND.
- IDLE:
  - snap_req = 1 at an edge: shadow <= q as it was before that edge, so same-cycle loads and clear are NOT captured.
  - Same edge: state <= SEND, out_ch <= 0, out_valid <= 1, out_data <= q_0 (pre-edge), out_last <= 0.
  - snap_busy = 1 from the next cycle.
- SEND:
  - Transfer occurs on an edge where out_valid & out_ready = 1.
  - Without a transfer, out_valid, out_data, out_ch and out_last hold stable. Back-pressure is unlimited.
  - Transfer with out_ch < NUM_CH-1: out_ch increments and out_data <= shadow[out_ch+1].
  - out_last = 1 exactly when out_ch = NUM_CH-1.
  - Transfer with out_last = 1: state <= IDLE, out_valid <= 0, snap_busy <= 0, out_ch <= 0.
  - With out_ready held high, the full stream takes NUM_CH cycles. The earliest next snap_req is accepted on the edge after returning to IDLE.
- snap_busy = 1 iff state = SEND.
- snap_req while in SEND is ignored; no queuing.
- load_en and clear during SEND update q normally but never alter shadow or the stream in progress.
- out_valid never drops without a transfer.

Test Plan:
- Reset/clear: assert rst_n = 0 mid-cycle -> q = 0 and out_valid = 0 immediately. Load all channels with 0xFF, then clear = 1 together with load_en = 4'b1111 -> q = 0 next cycle.
- Selective load: WIDTH = 8, NUM_CH = 4, d = 0x44332211, load_en = 4'b0101 from zero -> q = 0x00330011. load_en = 0 for 5 cycles -> q unchanged.
- Stream, no stall: q = 0xDDCCBBAA, snap_req one cycle, out_ready = 1 -> out_data 0xAA, 0xBB, 0xCC, 0xDD on out_ch 0..3 in 4 consecutive cycles. out_last is high only with 0xDD. snap_busy falls after the last transfer.
- Back-pressure and isolation: stream 0x04030201, out_ready low for 3 cycles on channel 1 -> out_data = 0x02 held stable. Meanwhile load d = 0xFFFFFFFF to all channels -> stream still delivers 0x03 and 0x04, while q = 0xFFFFFFFF. A snap_req issued during SEND produces no second stream.
- Same-edge snapshot: snap_req coincident with a load of channel 0 from 0x11 to 0x99 -> stream word 0 = 0x11 and q_0 = 0x99.
- Reset mid-stream, then restart: rst_n low during channel 2 -> IDLE and all outputs 0. After release, load 0x0000AA55 and snap_req -> stream restarts at out_ch = 0 with 0x55.
